icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
Direct-mapped instruction cache that answers the fetch stage's 64-bit bundle port. For each 8-byte-aligned fetch address it returns the bundle combinationally on a hit. On a miss it asserts stall and refills the whole line from a 32-bit memory bus over a valid/ready request channel and an in-order response channel. It sits between the fetch stage and the instruction memory/interconnect.

Parameters:
NUM_LINES, 16, number of cache lines; power of two, >=2.
LINE_WORDS, 4, 32-bit words per line; power of two, >=2, so a line holds an integer number of 64-bit bundles.
Derived: OFF_W = log2(LINE_WORDS*4), IDX_W = log2(NUM_LINES), TAG_W = 32-OFF_W-IDX_W.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
inst_addr  in  32  fetch address; bits [2:0] ignored (always bundle-aligned).
inst_rdata  out  64  bundle for inst_addr; word at addr+4 in [63:32], word at addr in [31:0].
inst_stall  out  1  high when inst_rdata is not valid for the current inst_addr; fetch must hold.
flush  in  1  one-cycle pulse; invalidate all lines.
mem_req_valid  out  1  line refill request valid.
mem_req_ready  in  1  request accepted when valid&&ready.
mem_req_addr  out  32  line-aligned refill address (low OFF_W bits zero).
mem_rsp_valid  in  1  one response word valid.
mem_rsp_data  in  32  response word; words arrive in ascending address order.
hit_count  out  32  wrapping count of cycles in IDLE with a hit.
miss_count  out  32  wrapping count of IDLE->REQ transitions.

Behaviour:
- Reset (async): all valid bits 0, FSM=IDLE, fill counter 0, counters 0, mem_req_valid 0. The data/tag arrays are not reset. inst_stall is 1 during reset because no line is valid. inst_rdata is don't-care whenever inst_stall=1.
- Lookup (combinational): idx=inst_addr[OFF_W+IDX_W-1:OFF_W], tag=inst_addr[31:OFF_W+IDX_W]. hit = (state==IDLE) && valid[idx] && tag_arr[idx]==tag. inst_stall = !hit. inst_rdata = data words {w[2k+1], w[2k]} of line idx, where k = inst_addr[OFF_W-1:3].
- FSM, 3 states:
  - IDLE: on miss, latch miss_line = inst_addr[31:OFF_W], clear valid[idx], go REQ. miss_count increments in the same cycle.
  - REQ: mem_req_valid=1, mem_req_addr={miss_line, OFF_W'b0}. Both are held stable until mem_req_ready. On handshake, go FILL with the fill counter at 0.
  - FILL: each mem_rsp_valid writes mem_rsp_data to word[counter] of the latched index and increments the counter. On the beat where counter==LINE_WORDS-1: write the tag, set valid unless a flush hit this fill, and go IDLE.
- Refill latency: the earliest hit is the cycle after the last beat, so minimum miss penalty = 1 (detect) + 1 (REQ, ready high) + LINE_WORDS beats.
- mem_rsp_valid outside FILL is ignored.
- inst_addr changing during REQ/FILL (fetch redirect): the outstanding refill is still completed, never aborted, and uses the latched address. Lookup resumes in IDLE with the new address, which may miss again.
- flush:
  - In IDLE or REQ: all valid bits clear next cycle.
  - During FILL: all valid bits clear, a flush_pending flag is set, and the line being filled ends invalid. flush_pending clears on return to IDLE.
  - flush in the same cycle as a miss in IDLE: the flush is applied and the FSM still goes to REQ.
- Only one refill is outstanding at a time; no request is issued in FILL.
- Counters wrap modulo 2^32.

Test Plan:
- Cold miss, NUM_LINES=16, LINE_WORDS=4: inst_addr=0x0 -> inst_stall=1; one request with mem_req_addr=0x0; beats 0xA0,0xA1,0xA2,0xA3 -> next cycle inst_stall=0, inst_rdata=0x000000A1_000000A0. Then inst_addr=0x8 -> hit, inst_rdata=0x000000A3_000000A2, hit_count increments.
- Conflict: after line 0x0 is filled, inst_addr=0x100 (same index 0, tag 1) -> miss, mem_req_addr=0x100, refill. Returning to 0x0 -> miss again; miss_count=3.
- Backpressure: hold mem_req_ready=0 for 3 cycles -> mem_req_valid=1 and mem_req_addr unchanged each cycle, exactly one handshake, inst_stall=1 throughout.
- Redirect mid-fill: change inst_addr 0x0->0x40 after the 2nd beat -> fill of 0x0 completes, then a new request for 0x40. A later access to 0x0 hits.
- Flush in FILL: flush pulse on beat 1 -> after the last beat the FSM is in IDLE, still misses at 0x0, and a new request for 0x0 is issued.
- Reset mid-FILL: assert rst_n=0 asynchronously -> mem_req_valid=0 immediately, counters 0. After release, inst_addr=0x0 misses and a fresh request is issued; stray mem_rsp_valid before the request is ignored.

Source files
------------

// File: rtl/icache_dm.sv
// ----------------------------------------------------------------------------
// icache_dm
//
// Direct-mapped instruction cache serving a 64-bit fetch bundle port. A hit
// returns the bundle combinationally. A miss stalls fetch and refills the
// whole line from a 32-bit memory bus. The bus has a valid/ready request
// channel and an in-order response channel, and only one refill is in
// flight at a time.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   inst_addr      fetch address (bits [2:0] ignored)
//   inst_rdata     bundle {word @ addr+4, word @ addr}, valid when !inst_stall
//   inst_stall     fetch must hold the address
//   flush          one-cycle pulse that invalidates every line
//   mem_req_valid  refill request valid
//   mem_req_ready  refill request accepted
//   mem_req_addr   line-aligned refill address
//   mem_rsp_valid  one response word valid
//   mem_rsp_data   response word, ascending address order
//   hit_count      wrapping count of hit cycles
//   miss_count     wrapping count of misses (IDLE -> REQ transitions)
// ----------------------------------------------------------------------------
module icache_dm #(
   parameter int NUM_LINES  = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_addr,
   output logic [63:0] inst_rdata,
   output logic        inst_stall,
   input  logic        flush,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int OFF_W  = $clog2(LINE_WORDS * 4);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int LINE_W = 32 - OFF_W;          // tag + index
   localparam int WSEL_W = $clog2(LINE_WORDS);  // word select within a line

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL
   } state_t;

   state_t              state;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]    tag_arr  [NUM_LINES];
   logic [31:0]         data_arr [NUM_LINES][LINE_WORDS];
   logic [LINE_W-1:0]   miss_line;
   logic [WSEL_W-1:0]   fill_cnt;
   logic                flush_pending;

   // ---------------------------------------------------------------------
   // Lookup
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [WSEL_W-1:0] wsel;
   logic [WSEL_W-1:0] word_lo;
   logic [WSEL_W-1:0] word_hi;
   logic              hit;
   logic              unused_addr_bits;

   assign idx  = inst_addr[OFF_W+IDX_W-1:OFF_W];
   assign tag  = inst_addr[31:OFF_W+IDX_W];
   assign wsel = inst_addr[OFF_W-1:2];

   // The bundle always starts on an even word. Masking the select (rather
   // than slicing above bit 2) keeps this legal when a line is one bundle.
   assign word_lo = wsel & ~WSEL_W'(1);
   assign word_hi = word_lo | WSEL_W'(1);

   // Bundle alignment makes the byte offset within the bundle meaningless.
   assign unused_addr_bits = ^inst_addr[2:0];

   assign hit        = (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);
   assign inst_stall = ~hit;
   assign inst_rdata = {data_arr[idx][word_hi], data_arr[idx][word_lo]};

   // ---------------------------------------------------------------------
   // Refill side
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             fill_beat;
   logic             last_beat;

   assign fill_idx  = miss_line[IDX_W-1:0];
   assign fill_tag  = miss_line[LINE_W-1:IDX_W];
   assign fill_beat = (state == FILL) && mem_rsp_valid;
   assign last_beat = fill_beat && (fill_cnt == WSEL_W'(LINE_WORDS - 1));

   // The miss line register is only written in IDLE, so the request address
   // stays stable through any amount of backpressure.
   assign mem_req_addr = {miss_line, {OFF_W{1'b0}}};

   // NOTE: every register below is assigned with <= so that each one samples
   // the values from before the clock edge, whatever order the statements
   // appear in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         valid         <= '0;
         miss_line     <= '0;
         fill_cnt      <= '0;
         flush_pending <= 1'b0;
         mem_req_valid <= 1'b0;
         hit_count     <= '0;
         miss_count    <= '0;
      end else begin
         if (hit) begin
            hit_count <= hit_count + 32'd1;
         end

         case (state)
            IDLE: begin
               if (!hit) begin
                  miss_line     <= inst_addr[31:OFF_W];
                  mem_req_valid <= 1'b1;
                  miss_count    <= miss_count + 32'd1;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  fill_cnt      <= '0;
                  state         <= FILL;
               end
            end
            FILL: begin
               if (mem_rsp_valid) begin
                  fill_cnt <= fill_cnt + WSEL_W'(1);
                  if (last_beat) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // A flush overrides everything. A line whose fill saw a flush
         // (earlier, or on this very beat) must not come back valid.
         if (flush) begin
            valid <= '0;
         end else if ((state == IDLE) && !hit) begin
            valid[idx] <= 1'b0;
         end else if (last_beat && !flush_pending) begin
            valid[fill_idx] <= 1'b1;
         end

         if (last_beat) begin
            flush_pending <= 1'b0;
         end else if (flush && (state == FILL)) begin
            flush_pending <= 1'b1;
         end
      end
   end

   // NOTE: the tag and data arrays have no reset. A line is only trusted once
   // its valid bit is set, and leaving the arrays unreset lets them map onto
   // plain RAM.
   always_ff @(posedge clk) begin
      if (fill_beat) begin
         data_arr[fill_idx][fill_cnt] <= mem_rsp_data;
         if (last_beat) begin
            tag_arr[fill_idx] <= fill_tag;
         end
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// ----------------------------------------------------------------------------
// tb_icache_dm
//
// Self-checking bench for icache_dm (NUM_LINES=16, LINE_WORDS=4).
// - A memory responder serves refill requests. It applies optional
//   backpressure and an optional response gap, and drives junk response
//   beats whenever no fill is in progress.
// - Expected refill addresses and expected bundles are queued when
//   stimulus is driven, then popped when the DUT handshakes or un-stalls.
// ----------------------------------------------------------------------------
module tb_icache_dm;

   localparam int LW = 4;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_addr;
   logic [63:0] inst_rdata;
   logic        inst_stall;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   icache_dm #(.NUM_LINES(16), .LINE_WORDS(LW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .inst_addr     (inst_addr),
      .inst_rdata    (inst_rdata),
      .inst_stall    (inst_stall),
      .flush         (flush),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   always #5 clk = ~clk;

   int n_checks   = 0;
   int n_errors   = 0;
   int exp_hits   = 0;
   int exp_misses = 0;
   int bp_cycles  = 0;
   bit rsp_gap    = 1'b0;
   int beats_done = 0;
   int hs_count   = 0;

   logic [31:0] exp_req [$];
   logic [63:0] data_q  [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Backing memory contents: line 0 reads 0xA0, 0xA1, 0xA2, 0xA3.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA0 + (a >> 2) + {a[15:4], 20'h0};
   endfunction

   function automatic logic [63:0] bundle(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'h7;
      return {mem_word(b + 32'd4), mem_word(b)};
   endfunction

   always @(negedge clk) begin
      if (rst_n && mem_req_valid && mem_req_ready) hs_count++;
   end

   // Memory responder.
   initial begin
      logic [31:0] cap;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = JUNK;
      forever begin
         @(posedge clk); #1;
         if (rst_n && mem_req_valid) begin
            cap = mem_req_addr;
            for (int i = 0; i < bp_cycles; i++) begin
               mem_req_ready = 1'b0;
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = JUNK;
               @(negedge clk);
               check("bp_req_valid", 64'(mem_req_valid), 64'd1);
               check("bp_req_addr", 64'(mem_req_addr), 64'(cap));
               check("bp_stall", 64'(inst_stall), 64'd1);
               @(posedge clk); #1;
            end
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = JUNK;
            @(negedge clk);
            check("req_expected", 64'(exp_req.size() != 0), 64'd1);
            if (exp_req.size() != 0) check("req_addr", 64'(mem_req_addr), 64'(exp_req.pop_front()));
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            for (int w = 0; w < LW; w++) begin
               if (!rst_n) break;
               if (rsp_gap && w == 2) begin
                  mem_rsp_valid = 1'b0;
                  mem_rsp_data  = JUNK;
                  @(posedge clk); #1;
                  if (!rst_n) break;
               end
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = mem_word(cap + 32'(4 * w));
               beats_done++;
               @(posedge clk); #1;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = JUNK;
         end else begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = JUNK;
         end
      end
   end

   // Wait for the DUT to un-stall, compare against the queued bundle, then
   // let the hit cycle complete. Returns the number of stalled cycles.
   task automatic wait_hit(output int stalls);
      logic [63:0] exp;
      bit ok;
      ok     = 1'b0;
      stalls = 0;
      exp    = (data_q.size() != 0) ? data_q.pop_front() : 64'hx;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (!inst_stall) begin
            ok = 1'b1;
            break;
         end
         stalls++;
         @(posedge clk); #1;
      end
      check("hit_reached", 64'(ok), 64'd1);
      if (ok) begin
         check("bundle", inst_rdata, exp);
         exp_hits++;
      end
      @(posedge clk); #1;
   endtask

   task automatic fetch(input logic [31:0] a, input int exp_stalls);
      int s;
      inst_addr = a;
      data_q.push_back(bundle(a));
      wait_hit(s);
      if (exp_stalls >= 0) check("stall_cycles", 64'(s), 64'(exp_stalls));
   endtask

   task automatic wait_beats(input int target);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (beats_done >= target) begin
            ok = 1'b1;
            break;
         end
      end
      check("beat_wait", 64'(ok), 64'd1);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_hits"}, 64'(hit_count), 64'(exp_hits));
      check({tag, "_misses"}, 64'(miss_count), 64'(exp_misses));
   endtask

   initial begin
      int s, h0, b0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      inst_addr = 32'h0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 64'(inst_stall), 64'd1);
      check("rst_req_valid", 64'(mem_req_valid), 64'd0);
      check_counters("rst");

      // Cold miss at 0x0 with minimum penalty, then the second bundle hits.
      @(posedge clk); #1;
      exp_req.push_back(32'h0);
      data_q.push_back(bundle(32'h0));
      rst_n = 1'b1;
      wait_hit(s);
      exp_misses++;
      check("cold_stalls", 64'(s), 64'd6);
      check("cold_one_req", 64'(hs_count), 64'd1);
      fetch(32'h8, 0);
      check_counters("cold");

      // Conflict on index 0, with a gap in the response stream.
      rsp_gap = 1'b1;
      exp_req.push_back(32'h100);
      fetch(32'h100, 7);
      rsp_gap = 1'b0;
      exp_req.push_back(32'h0);
      fetch(32'h0, 6);
      exp_misses += 2;
      check_counters("conflict");

      // Backpressure: ready low for 3 cycles in REQ.
      bp_cycles = 3;
      h0 = hs_count;
      exp_req.push_back(32'h200);
      fetch(32'h200, 9);
      bp_cycles = 0;
      exp_misses++;
      check("bp_one_handshake", 64'(hs_count - h0), 64'd1);

      // Redirect 0x0 -> 0x40 after the second beat.
      b0 = beats_done;
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h40);
      inst_addr = 32'h0;
      wait_beats(b0 + 2);
      @(posedge clk); #1;
      inst_addr = 32'h40;
      data_q.push_back(bundle(32'h40));
      wait_hit(s);
      exp_misses += 2;
      fetch(32'h0, 0);
      check_counters("redirect");

      // Flush together with a miss in IDLE: the refill still goes ahead.
      inst_addr = 32'h100;
      flush     = 1'b1;
      exp_req.push_back(32'h100);
      data_q.push_back(bundle(32'h100));
      @(posedge clk); #1;
      flush = 1'b0;
      wait_hit(s);
      exp_misses++;
      exp_req.push_back(32'h40);
      fetch(32'h40, -1);
      exp_misses++;
      check("flush_cleared_other", 64'(s != 0), 64'd1);

      // Flush on beat 1 of a fill: the line ends invalid and is re-requested.
      b0 = beats_done;
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h0);
      inst_addr = 32'h0;
      data_q.push_back(bundle(32'h0));
      wait_beats(b0 + 1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      h0 = hs_count;
      wait_hit(s);
      exp_misses += 2;
      check("flush_fill_rereq", 64'(hs_count - h0), 64'd1);
      check_counters("flush");

      // Asynchronous reset in the middle of a fill.
      b0 = beats_done;
      exp_req.push_back(32'h300);
      inst_addr = 32'h300;
      wait_beats(b0 + 2);
      #2;
      rst_n = 1'b0;
      #1;
      exp_hits   = 0;
      exp_misses = 0;
      check("mid_rst_req_valid", 64'(mem_req_valid), 64'd0);
      check("mid_rst_stall", 64'(inst_stall), 64'd1);
      check_counters("mid_rst");
      inst_addr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      exp_req.push_back(32'h0);
      data_q.push_back(bundle(32'h0));
      rst_n = 1'b1;
      wait_hit(s);
      exp_misses++;
      check("post_rst_stalls", 64'(s), 64'd6);
      check_counters("post_rst");

      check("req_queue_drained", 64'(exp_req.size()), 64'd0);
      check("data_queue_drained", 64'(data_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
